// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit: issues one fetch at a time, hands the word to decode,
// then waits for retirement to learn the next PC.
module ysyx_24100006_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        wb_valid,
   input  logic [31:0] wb_npc,
   output logic        fetch_err,
   output logic        fetch_timeout,
   output logic [31:0] retire_cnt
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 8;
   localparam logic [XLEN-1:0] EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_VALID,
      S_WAITWB
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              resp_take;
   logic              wb_take;
   logic [XLEN-1:0]   pc;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  wait_cnt_inc;

   assign mem_req_addr = pc;

   // Next-state decode and single-cycle acceptance strobes
   always_comb begin
      state_nxt    = state;
      resp_take    = 1'b0;
      wb_take      = 1'b0;
      wait_cnt_inc = (wait_cnt == TIMEOUT) ? wait_cnt : wait_cnt + CNT_W'(1);
      case (state)
         S_IDLE:   state_nxt = S_REQ;
         S_REQ:    if (mem_req_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            if (mem_resp_valid) begin
               state_nxt = S_VALID;
               resp_take = 1'b1;
            end
         end
         S_VALID:  if (inst_ready) state_nxt = S_WAITWB;
         S_WAITWB: begin
            if (wb_valid) begin
               state_nxt = S_REQ;
               wb_take   = 1'b1;
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register; handshake outputs registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         mem_req_valid  <= 1'b0;
         mem_resp_ready <= 1'b0;
         inst_valid     <= 1'b0;
      end else begin
         state          <= state_nxt;
         mem_req_valid  <= (state_nxt == S_REQ);
         mem_resp_ready <= (state_nxt == S_WAIT);
         inst_valid     <= (state_nxt == S_VALID);
      end
   end

   // Fetch datapath: instruction latch, PC update, retire count, sticky flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc            <= RESET_PC;
         inst          <= '0;
         inst_pc       <= '0;
         retire_cnt    <= '0;
         fetch_err     <= 1'b0;
         fetch_timeout <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         if (resp_take) begin
            inst    <= mem_resp_err ? EBREAK : mem_resp_data;
            inst_pc <= pc;
            if (mem_resp_err) fetch_err <= 1'b1;
         end
         if (wb_take) begin
            pc         <= {wb_npc[XLEN-1:2], 2'b00};
            retire_cnt <= retire_cnt + XLEN'(1);
            if (wb_npc[1:0] != 2'b00) fetch_err <= 1'b1;
         end
         if (state == S_REQ && state_nxt == S_WAIT) begin
            wait_cnt <= '0;
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT) fetch_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// Directed bench for the fetch unit: table of full fetch/retire transactions
// plus hand-written stall, timeout and reset sequences.
module tb_ysyx_24100006_ifu;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        wb_valid;
   logic [31:0] wb_npc;
   logic        fetch_err;
   logic        fetch_timeout;
   logic [31:0] retire_cnt;

   int n_vec = 0;
   int n_bad = 0;

   ysyx_24100006_ifu dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .wb_valid       (wb_valid),
      .wb_npc         (wb_npc),
      .fetch_err      (fetch_err),
      .fetch_timeout  (fetch_timeout),
      .retire_cnt     (retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst_before;
      logic [31:0] data;
      bit          err;
      logic [31:0] npc;
      logic [31:0] exp_addr;
      logic [31:0] exp_inst;
      bit          exp_err;
      logic [31:0] exp_retire;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      inst_ready     = 1'b0;
      wb_valid       = 1'b0;
      wb_npc         = '0;
   endtask

   // Assert reset mid-cycle, check it takes effect without an edge, then release
   task automatic do_reset();
      #2;
      reset = 1'b0;
      clear_inputs();
      #1;
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_addr", mem_req_addr, 32'h8000_0000);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_fetch_err", 32'(fetch_err), 32'd0);
      chk("rst_timeout", 32'(fetch_timeout), 32'd0);
      step();
      step();
      chk("rst_hold_req_valid", 32'(mem_req_valid), 32'd0);
      reset = 1'b1;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!mem_req_valid && n < 20) begin
         step();
         n++;
      end
      chk("req_valid", 32'(mem_req_valid), 32'd1);
   endtask

   // One zero-wait fetch followed by retirement
   task automatic fetch(input vec_t v, input bit check_lat);
      int n;
      wait_req(n);
      if (check_lat) chk("req_latency", 32'(n), 32'd0);
      chk("req_addr", mem_req_addr, v.exp_addr);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      chk("resp_ready", 32'(mem_resp_ready), 32'd1);
      mem_resp_valid = 1'b1;
      mem_resp_data  = v.data;
      mem_resp_err   = v.err;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      chk("inst_valid", 32'(inst_valid), 32'd1);
      chk("inst", inst, v.exp_inst);
      chk("inst_pc", inst_pc, v.exp_addr);
      chk("fetch_err", 32'(fetch_err), 32'(v.exp_err));
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("inst_valid_drop", 32'(inst_valid), 32'd0);
      wb_valid = 1'b1;
      wb_npc   = v.npc;
      step();
      wb_valid = 1'b0;
      chk("retire_cnt", retire_cnt, v.exp_retire);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      clear_inputs();

      vecs[0] = '{1'b0, 32'h0000_0413, 1'b0, 32'h8000_0010, 32'h8000_0000, 32'h0000_0413, 1'b0, 32'd1};
      vecs[1] = '{1'b0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0020, 32'h8000_0010, 32'h0010_0073, 1'b1, 32'd2};
      vecs[2] = '{1'b0, 32'h0000_0013, 1'b0, 32'h8000_0024, 32'h8000_0020, 32'h0000_0013, 1'b1, 32'd3};
      vecs[3] = '{1'b1, 32'h0000_0297, 1'b0, 32'h8000_0012, 32'h8000_0000, 32'h0000_0297, 1'b0, 32'd1};
      vecs[4] = '{1'b0, 32'h00A0_0513, 1'b0, 32'h8000_0100, 32'h8000_0010, 32'h00A0_0513, 1'b1, 32'd2};
      vecs[5] = '{1'b0, 32'h0000_0000, 1'b0, 32'h8000_0103, 32'h8000_0100, 32'h0000_0000, 1'b1, 32'd3};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0004, 32'h8000_0100, 32'hFFFF_FFFF, 1'b1, 32'd4};
      vecs[7] = '{1'b0, 32'h0000_0073, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0073, 1'b1, 32'd5};

      step();
      do_reset();

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].rst_before) do_reset();
         fetch(vecs[i], (i > 0) && !vecs[i].rst_before);
      end

      // Request held with a stable address while memory is not ready; stray responses ignored
      wait_req(n);
      for (int c = 0; c < 3; c++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'h1111_1111;
         step();
         chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
         chk("req_hold_addr", mem_req_addr, 32'h0000_0000);
         chk("req_hold_no_inst", 32'(inst_valid), 32'd0);
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_0513;
      step();

      // Decode stalls for 5 cycles: output stable, no new request, wb ignored
      for (int c = 0; c < 5; c++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'h0BAD_0BAD;
         wb_valid       = 1'b1;
         wb_npc         = 32'h0000_0040;
         step();
         chk("stall_inst_valid", 32'(inst_valid), 32'd1);
         chk("stall_inst", inst, 32'h0000_0513);
         chk("stall_inst_pc", inst_pc, 32'h0000_0000);
         chk("stall_no_req", 32'(mem_req_valid), 32'd0);
         chk("stall_retire", retire_cnt, 32'd5);
      end
      mem_resp_valid = 1'b0;
      wb_valid       = 1'b0;
      inst_ready     = 1'b1;
      step();
      inst_ready = 1'b0;
      wb_valid   = 1'b1;
      wb_npc     = 32'h0000_0040;
      step();
      wb_valid = 1'b0;
      chk("stall_retire_after", retire_cnt, 32'd6);
      chk("stall_next_req", 32'(mem_req_valid), 32'd1);
      chk("stall_next_addr", mem_req_addr, 32'h0000_0040);

      // Memory never answers: timeout after 255 cycles in WAIT
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("to_in_wait", 32'(mem_resp_ready), 32'd1);
      repeat (254) step();
      chk("to_not_yet", 32'(fetch_timeout), 32'd0);
      step();
      chk("to_set", 32'(fetch_timeout), 32'd1);
      chk("to_still_wait", 32'(mem_resp_ready), 32'd1);
      chk("to_no_inst", 32'(inst_valid), 32'd0);
      step();
      chk("to_sticky", 32'(fetch_timeout), 32'd1);

      // Reset mid-WAIT, then a late response must be dropped
      do_reset();
      for (int c = 0; c < 3; c++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'h0000_0040;
         step();
         chk("late_req_valid", 32'(mem_req_valid), 32'd1);
         chk("late_addr", mem_req_addr, 32'h8000_0000);
         chk("late_no_inst_valid", 32'(inst_valid), 32'd0);
         chk("late_inst", inst, 32'd0);
         chk("late_timeout", 32'(fetch_timeout), 32'd0);
      end
      mem_resp_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
